// File: rtl/tl45_fetch.sv
// tl45_fetch: instruction fetch stage feeding decode.
// Masters a pipelined Wishbone read bus, keeps the PC and presents one
// {pc, instruction} pair per fetch. All other times it presents an all-zero bubble.
// Optional build macro: TL45_FETCH_BUSERR_TRAP_EN.
//   Defined: a bus error delivers an illegal-opcode word with o_fetch_err set,
//            then halts fetching until a flush.
//   Undefined: a bus error retries the same PC, and o_fetch_err stays 0.
//
// Decode handshake: o_buf_pc/o_buf_inst hold a valid pair while out_valid_q is 1.
// The pair is consumed on the rising edge where i_pipe_stall is 0.
// While i_pipe_stall is 1 the pair is held unchanged.
// A new bus request is only issued once the pair has been consumed, so the
// stage never needs a second holding register.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_new_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_REQ     = 3'd0,
    S_ACK     = 3'd1,
    S_HOLD    = 3'd2,
    S_DISCARD = 3'd3
`ifdef TL45_FETCH_BUSERR_TRAP_EN
    ,
    S_HALT    = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        fetch_err_q, fetch_err_d;
  logic        out_valid_q, out_valid_d;

  // The two low bits of a redirect target are always dropped.
  logic unused_new_pc_lsb;
  assign unused_new_pc_lsb = ^i_new_pc[1:0];

  // Register all stage state. Reset is asynchronous and lands on a request of RESET_PC.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      buf_pc_q    <= 32'h0;
      buf_inst_q  <= 32'h0;
      fetch_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      fetch_err_q <= fetch_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and next-buffer logic. A flush overrides everything computed above it.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    fetch_err_d = fetch_err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_REQ: begin
        if (!i_wb_stall) state_d = S_ACK;
      end
      S_ACK: begin
        if (i_wb_ack) begin
          buf_pc_d    = pc_q;
          buf_inst_d  = i_wb_data;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
          state_d     = S_HOLD;
        end else if (i_wb_err) begin
`ifdef TL45_FETCH_BUSERR_TRAP_EN
          // Opcode 5'h1F is illegal, so decode flags the trap itself.
          buf_pc_d    = pc_q;
          buf_inst_d  = 32'hFFFF_FFFF;
          fetch_err_d = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_HALT;
`else
          state_d     = S_REQ;
`endif
        end
      end
      S_HOLD: begin
        if (!i_pipe_stall || !out_valid_q) begin
          buf_pc_d    = 32'h0;
          buf_inst_d  = 32'h0;
          fetch_err_d = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
`ifdef TL45_FETCH_BUSERR_TRAP_EN
      S_HALT: begin
        if (!i_pipe_stall && out_valid_q) begin
          buf_pc_d    = 32'h0;
          buf_inst_d  = 32'h0;
          fetch_err_d = 1'b0;
          out_valid_d = 1'b0;
        end
      end
`endif
      S_DISCARD: begin
        if (i_wb_ack || i_wb_err) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (i_pipe_flush) begin
      buf_pc_d    = 32'h0;
      buf_inst_d  = 32'h0;
      fetch_err_d = 1'b0;
      out_valid_d = 1'b0;
      pc_d        = {i_new_pc[31:2], 2'b00};
      case (state_q)
        // An accepted strobe still owes us a response that must be dropped.
        S_REQ:            state_d = i_wb_stall ? S_REQ : S_DISCARD;
        // A response arriving with the flush closes the bus cycle right away.
        S_ACK, S_DISCARD: state_d = (i_wb_ack || i_wb_err) ? S_REQ : S_DISCARD;
        default:          state_d = S_REQ;
      endcase
    end
  end

  // Bus control is decoded from the state. Reset kills the cycle immediately.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    if (!i_reset) begin
      case (state_q)
        S_REQ: begin
          o_wb_cyc = 1'b1;
          o_wb_stb = 1'b1;
        end
        S_ACK, S_DISCARD: o_wb_cyc = 1'b1;
        default: begin
          o_wb_cyc = 1'b0;
          o_wb_stb = 1'b0;
        end
      endcase
    end
  end

  assign o_wb_addr   = pc_q[31:2];
  assign o_buf_pc    = buf_pc_q;
  assign o_buf_inst  = buf_inst_q;
  assign o_fetch_err = fetch_err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tl45_fetch.sv
// tb_tl45_fetch: directed bench for tl45_fetch.
// The bench has three parts:
//   - A reactive Wishbone slave with knobs for latency, stalls, errors and data override.
//   - A stream-level model of the expected fetch sequence:
//       * the PC runs sequentially from the last redirect;
//       * each delivered word must equal memory at its PC;
//       * a pair is held while stalled and cleared once consumed.
//   - Literal per-scenario checks.
module tb_tl45_fetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        i_clk;
  logic        i_reset;
  logic        i_pipe_stall;
  logic        i_pipe_flush;
  logic [31:0] i_new_pc;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic        i_wb_err;
  logic [31:0] i_wb_data;
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;
  logic        o_fetch_err;
  logic [2:0]  o_dbg_state;

  tl45_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pipe_stall (i_pipe_stall),
    .i_pipe_flush (i_pipe_flush),
    .i_new_pc     (i_new_pc),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_addr    (o_wb_addr),
    .i_wb_ack     (i_wb_ack),
    .i_wb_stall   (i_wb_stall),
    .i_wb_err     (i_wb_err),
    .i_wb_data    (i_wb_data),
    .o_buf_pc     (o_buf_pc),
    .o_buf_inst   (o_buf_inst),
    .o_fetch_err  (o_fetch_err),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- counters, expected queue, model state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] p_pc, p_inst;
  logic        p_err;

  // Slave knobs are owned by the driver; tickets are consumed by the slave.
  int          slv_latency   = 0;
  int          slv_stall_req = 0;
  int          slv_err_req   = 0;
  int          slv_ovr_req   = 0;
  logic [31:0] slv_ovr_data  = 32'hDEAD_BEEF;
  int          slv_stall_done = 0;
  int          slv_err_done   = 0;
  int          slv_ovr_done   = 0;
  int          slv_acks       = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h0810_0005 + (pc << 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Wishbone slave ----------------
  initial begin : slave
    logic        pend;
    int          cnt;
    logic [29:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
    forever begin
      @(negedge i_clk);
      #2;
      i_wb_ack  = 1'b0;
      i_wb_err  = 1'b0;
      i_wb_data = '0;
      if (i_reset || !o_wb_cyc) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          pend = 1'b0;
          slv_acks++;
          if (slv_err_done < slv_err_req) begin
            i_wb_err = 1'b1;
            slv_err_done++;
          end else if (slv_ovr_done < slv_ovr_req) begin
            i_wb_ack  = 1'b1;
            i_wb_data = slv_ovr_data;
            slv_ovr_done++;
          end else begin
            i_wb_ack  = 1'b1;
            i_wb_data = mem_word({paddr, 2'b00});
          end
        end else begin
          cnt--;
        end
      end
      i_wb_stall = 1'b0;
      if (!i_reset && o_wb_stb) begin
        if (slv_stall_done < slv_stall_req) begin
          i_wb_stall = 1'b1;
          slv_stall_done++;
        end else begin
          pend  = 1'b1;
          cnt   = slv_latency;
          paddr = o_wb_addr;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the stream model ----------------
  task automatic step();
    @(negedge i_clk);
    if (i_reset) begin
      m_pc   = TB_RESET_PC;
      m_halt = 1'b0;
      p_pc   = '0;
      p_inst = '0;
      p_err  = 1'b0;
      exp_q.delete();
    end else begin
      if (i_pipe_flush) begin
        m_pc   = {i_new_pc[31:2], 2'b00};
        m_halt = 1'b0;
        check("flush_clears_inst", o_buf_inst, 32'h0);
        check("flush_clears_pc", o_buf_pc, 32'h0);
      end else if (p_inst != 32'h0) begin
        if (i_pipe_stall) begin
          check("stall_holds_pc", o_buf_pc, p_pc);
          check("stall_holds_inst", o_buf_inst, p_inst);
          check("stall_holds_err", {31'h0, o_fetch_err}, {31'h0, p_err});
        end else begin
          check("consume_clears_inst", o_buf_inst, 32'h0);
        end
      end else if (o_buf_inst != 32'h0) begin
        if (o_buf_inst == 32'hFFFF_FFFF && o_fetch_err) begin
`ifdef TL45_FETCH_BUSERR_TRAP_EN
          check("trap_pc", o_buf_pc, m_pc);
          m_halt = 1'b1;
`else
          check("no_trap_err", {31'h0, o_fetch_err}, 32'h0);
`endif
        end else begin
          exp_q.push_back(mem_word(m_pc));
          check("deliver_pc", o_buf_pc, m_pc);
          check("deliver_inst", o_buf_inst, exp_q.pop_front());
          check("deliver_err", {31'h0, o_fetch_err}, 32'h0);
          m_pc = m_pc + 32'd4;
        end
      end
      if (o_buf_inst == 32'h0) begin
        check("bubble_pc", o_buf_pc, 32'h0);
        check("bubble_err", {31'h0, o_fetch_err}, 32'h0);
      end
      if (o_wb_stb) begin
        check("stb_has_cyc", {31'h0, o_wb_cyc}, 32'h1);
        check("stb_addr", {2'b00, o_wb_addr}, {2'b00, m_pc[31:2]});
      end
      if (m_halt) check("halt_no_cyc", {31'h0, o_wb_cyc}, 32'h0);
      p_pc   = o_buf_pc;
      p_inst = o_buf_inst;
      p_err  = o_fetch_err;
    end
  endtask

  task automatic wait_stb(input int budget);
    int k = 0;
    while (!o_wb_stb && k < budget) begin
      step();
      k++;
    end
    check("stb_timeout", {31'h0, o_wb_stb}, 32'h1);
  endtask

  task automatic wait_deliv(input int budget);
    int k = 0;
    while (o_buf_inst == 32'h0 && k < budget) begin
      step();
      k++;
    end
    check("deliv_timeout", {31'h0, (o_buf_inst != 32'h0)}, 32'h1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : driver
    int acks0;
    i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; i_new_pc = '0;
    m_pc = TB_RESET_PC; m_halt = 1'b0; p_pc = '0; p_inst = '0; p_err = 1'b0;

    // Reset values
    step();
    check("rst_cyc", {31'h0, o_wb_cyc}, 32'h0);
    check("rst_stb", {31'h0, o_wb_stb}, 32'h0);
    check("rst_addr", {2'b00, o_wb_addr}, 32'h0);
    check("rst_buf_pc", o_buf_pc, 32'h0);
    check("rst_buf_inst", o_buf_inst, 32'h0);
    check("rst_fetch_err", {31'h0, o_fetch_err}, 32'h0);
    i_reset = 1'b0;

    // First fetch from a zero-wait slave, shown for exactly one cycle
    wait_deliv(20);
    check("t1_pc", o_buf_pc, 32'h0);
    check("t1_inst", o_buf_inst, 32'h0810_0005);
    step();
    check("t1_one_cycle", o_buf_inst, 32'h0);
    check("t1_next_stb", {31'h0, o_wb_stb}, 32'h1);
    check("t1_next_addr", {2'b00, o_wb_addr}, 32'h1);

    // Decode stall while holding pc=4
    i_pipe_stall = 1'b1;
    wait_deliv(20);
    check("t2_pc", o_buf_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_pc", o_buf_pc, 32'h4);
      check("t2_hold_inst", o_buf_inst, 32'h0810_0405);
      check("t2_no_cyc", {31'h0, o_wb_cyc}, 32'h0);
    end
    i_pipe_stall = 1'b0;
    step();
    check("t2_cleared", o_buf_inst, 32'h0);
    check("t2_next_addr", {2'b00, o_wb_addr}, 32'h2);
    check("t2_next_stb", {31'h0, o_wb_stb}, 32'h1);

    // Slave stalls the strobe for 3 cycles; redirect to 0x100 in cycle 2
    slv_stall_req = slv_stall_req + 3;
    step();
    check("t3_stb_held", {31'h0, o_wb_stb}, 32'h1);
    check("t3_addr_held", {2'b00, o_wb_addr}, 32'h2);
    i_pipe_flush = 1'b1; i_new_pc = 32'h100;
    step();
    i_pipe_flush = 1'b0;
    check("t3_retarget", {2'b00, o_wb_addr}, 32'h40);
    check("t3_stb", {31'h0, o_wb_stb}, 32'h1);
    wait_deliv(20);
    check("t3_pc", o_buf_pc, 32'h100);
    check("t3_inst", o_buf_inst, 32'h0811_0005);

    // Redirect to 0x200 while waiting for an ack; stale DEADBEEF must be dropped
    slv_latency = 2;
    slv_ovr_req = slv_ovr_req + 1;
    step();
    wait_stb(10);
    step();
    check("t4_ack_cyc", {31'h0, o_wb_cyc}, 32'h1);
    check("t4_ack_stb", {31'h0, o_wb_stb}, 32'h0);
    acks0 = slv_acks;
    i_pipe_flush = 1'b1; i_new_pc = 32'h200;
    step();
    i_pipe_flush = 1'b0;
    check("t4_discard_cyc", {31'h0, o_wb_cyc}, 32'h1);
    check("t4_discard_stb", {31'h0, o_wb_stb}, 32'h0);
    check("t4_stale_pending", slv_acks, acks0);
    slv_latency = 0;
    i_pipe_stall = 1'b1;
    wait_stb(20);
    check("t4_stale_seen", slv_acks, acks0 + 1);
    check("t4_new_addr", {2'b00, o_wb_addr}, 32'h80);
    wait_deliv(20);
    check("t4_pc", o_buf_pc, 32'h200);
    check("t4_inst", o_buf_inst, 32'h0812_0005);

    // Bus error at pc=0x10
    i_pipe_flush = 1'b1; i_new_pc = 32'h10;
    slv_err_req = slv_err_req + 1;
    step();
    i_pipe_flush = 1'b0;
    i_pipe_stall = 1'b0;
    check("t5_req_addr", {2'b00, o_wb_addr}, 32'h4);
    step();
    step();
`ifdef TL45_FETCH_BUSERR_TRAP_EN
    check("t5_trap_inst", o_buf_inst, 32'hFFFF_FFFF);
    check("t5_trap_pc", o_buf_pc, 32'h10);
    check("t5_trap_err", {31'h0, o_fetch_err}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_halt_cyc", {31'h0, o_wb_cyc}, 32'h0);
      check("t5_halt_bubble", o_buf_inst, 32'h0);
    end
    i_pipe_flush = 1'b1; i_new_pc = 32'h20;
    step();
    i_pipe_flush = 1'b0;
    check("t5_resume_addr", {2'b00, o_wb_addr}, 32'h8);
    wait_deliv(20);
    check("t5_after_pc", o_buf_pc, 32'h20);
`else
    check("t5_retry_stb", {31'h0, o_wb_stb}, 32'h1);
    check("t5_retry_addr", {2'b00, o_wb_addr}, 32'h4);
    check("t5_retry_bubble", o_buf_inst, 32'h0);
    wait_deliv(20);
    check("t5_after_pc", o_buf_pc, 32'h10);
    check("t5_after_inst", o_buf_inst, 32'h0810_1005);
`endif

    // Asynchronous reset while a read is outstanding
    slv_latency = 3;
    step();
    wait_stb(10);
    @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    #1;
    check("t6_cyc", {31'h0, o_wb_cyc}, 32'h0);
    check("t6_stb", {31'h0, o_wb_stb}, 32'h0);
    check("t6_buf_pc", o_buf_pc, 32'h0);
    check("t6_buf_inst", o_buf_inst, 32'h0);
    check("t6_addr", {2'b00, o_wb_addr}, {2'b00, TB_RESET_PC[31:2]});
    step();
    step();
    slv_latency = 0;
    i_reset = 1'b0;
    #1;
    check("t6_first_stb", {31'h0, o_wb_stb}, 32'h1);
    check("t6_first_addr", {2'b00, o_wb_addr}, {2'b00, TB_RESET_PC[31:2]});
    wait_deliv(20);
    check("t6_pc", o_buf_pc, TB_RESET_PC);
    check("t6_inst", o_buf_inst, 32'h0810_0005);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tl45_fetch.md
Name: tl45_fetch

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Masters a pipelined Wishbone read bus to instruction memory and maintains the PC.
- Presents one {pc, instruction} pair per fetch to decode, and a bubble (all-zero NOP) otherwise.
- Honours downstream stall and flush/redirect; a flush carries a new PC.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset, asynchronous and active-high.
- i_pipe_stall  in  1  decode stage holding; current o_buf_* not consumed this cycle.
- i_pipe_flush  in  1  redirect request; takes priority over stall.
- i_new_pc  in  32  redirect target, sampled when i_pipe_flush=1; bits [1:0] ignored (forced 0).
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe (read only; no write-enable port).
- o_wb_addr  out  30  word address = pc[31:2].
- i_wb_ack  in  1  read data valid.
- i_wb_stall  in  1  slave not accepting strobe.
- i_wb_err  in  1  bus error; terminates the cycle like ack.
- i_wb_data  in  32  instruction word.
- o_buf_pc  out  32  PC of o_buf_inst; 0 for a bubble.
- o_buf_inst  out  32  instruction to decode; 0 (NOP) for a bubble.
- o_fetch_err  out  1  registered; 1 while the held output came from a bus error.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=S_REQ.
  - o_buf_pc=0, o_buf_inst=0, o_fetch_err=0.
  - o_wb_cyc=0, o_wb_stb=0, o_wb_addr=RESET_PC[31:2].
  - Reset mid-bus-cycle drops cyc immediately; no discard is performed.
- Internal out_valid flag: 1 while o_buf_* holds an unconsumed instruction. A new request is issued only when out_valid=0, so no skid buffer is needed.
- S_REQ:
  - Outputs: cyc=1, stb=1, addr=pc[31:2].
  - If !i_wb_stall: request accepted -> S_ACK. Otherwise hold stb.
- S_ACK:
  - Outputs: cyc=1, stb=0.
  - On i_wb_ack: o_buf_pc<=pc, o_buf_inst<=i_wb_data, out_valid<=1, pc<=pc+4 (wraps mod 2^32), -> S_HOLD.
  - Ack never arrives in the same cycle the strobe is accepted.
- S_HOLD:
  - Outputs: cyc=0.
  - If !i_pipe_stall: decode consumes the pair at this edge. o_buf_pc/o_buf_inst<=0, o_fetch_err<=0, out_valid<=0, -> S_REQ.
  - If i_pipe_stall: all outputs hold.
  - Best-case throughput: 1 instruction per 3 cycles plus slave latency.
- S_DISCARD:
  - Outputs: cyc=1, stb=0.
  - Waits for i_wb_ack or i_wb_err; data is dropped. Then -> S_REQ with the already-updated pc.
- Bus error (i_wb_err in S_ACK): see Optional Feature. pc is not advanced.
- Flush (i_pipe_flush=1; overrides stall and all other transitions):
  - o_buf_pc/o_buf_inst<=0, o_fetch_err<=0, out_valid<=0, pc<={i_new_pc[31:2],2'b00}.
  - From S_ACK: -> S_DISCARD.
  - From S_REQ with stb accepted this cycle (!i_wb_stall): -> S_DISCARD.
  - From S_REQ with i_wb_stall=1: -> S_REQ; the strobe retargets to the new address next cycle.
  - From S_HOLD or S_HALT: -> S_REQ.
  - From S_DISCARD: stay; new pc replaces the pending target.
  - Ack/err coinciding with flush is discarded and the new state is S_REQ; the bus cycle is complete.
- Back-to-back flushes: the last i_new_pc wins.
- o_wb_stb is never 1 while o_wb_cyc=0.

Optional Feature:
- Macro: TL45_FETCH_BUSERR_TRAP_EN.
- Defined:
  - i_wb_err in S_ACK loads o_buf_pc<=pc, o_buf_inst<=32'hFFFF_FFFF (opcode 5'h1F, illegal, so decode raises decode_err), o_fetch_err<=1, out_valid<=1.
  - State -> S_HALT: cyc=0 and no further fetches until flush. Stall and consume rules match S_HOLD, except that consumption clears the outputs and stays in S_HALT.
- Undefined:
  - i_wb_err -> S_REQ, retrying the same pc indefinitely.
  - o_fetch_err is tied to 0 and S_HALT is absent.

Test Plan:
- Reset, zero-wait slave (ack 1 cycle after accept) returning 32'h0810_0005 at word 0, no stall -> o_buf_pc=0, o_buf_inst=32'h0810_0005 for exactly one cycle, then 0. Next request has o_wb_addr=1.
- i_pipe_stall=1 for 5 cycles while holding pc=4 -> o_buf_* stable and cyc=0 throughout. On release the outputs clear, then the next strobe goes to addr 2.
- i_wb_stall=1 for 3 cycles -> stb held with addr unchanged. Flush to 32'h100 in cycle 2 -> next strobe addr=32'h40, and the old address is never acked into the outputs.
- Flush to 32'h200 while in S_ACK, then ack with 32'hDEAD_BEEF -> the data never appears on o_buf_inst. The next request uses addr=32'h80, and cyc stays high until that stale ack.
- i_wb_err at pc=32'h10 with TRAP_EN -> o_buf_inst=32'hFFFF_FFFF, o_buf_pc=32'h10, o_fetch_err=1, no further cyc until flush. Without TRAP_EN -> retry strobe at addr 4.
- Assert i_reset mid-S_ACK (asynchronously, between edges) -> cyc/stb/o_buf_* go to 0 immediately. After release, the first strobe uses addr=RESET_PC[31:2].
